// File: rtl/ddr2_init_checker_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : ddr2_init_checker_if
// Brief   : DDR2 command pins seen by the init checker, plus the checker's
//           status and captured mode-register outputs.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
interface ddr2_init_checker_if #(
  parameter int BA_BITS   = 3,
  parameter int ADDR_BITS = 13
);
  logic                 ddr2_cke;
  logic                 ddr2_cs_n;
  logic                 ddr2_ras_n;
  logic                 ddr2_cas_n;
  logic                 ddr2_we_n;
  logic [BA_BITS-1:0]   ddr2_ba;
  logic [ADDR_BITS-1:0] ddr2_addr;

  logic                 init_done;
  logic                 err;
  logic [3:0]           err_code;
  logic [3:0]           step;
  logic [ADDR_BITS-1:0] mr_q;
  logic [ADDR_BITS-1:0] emr1_q;
  logic [ADDR_BITS-1:0] emr2_q;
  logic [ADDR_BITS-1:0] emr3_q;

  // Controller side: drives the command pins, observes the checker.
  modport master (
    output ddr2_cke, ddr2_cs_n, ddr2_ras_n, ddr2_cas_n, ddr2_we_n,
           ddr2_ba, ddr2_addr,
    input  init_done, err, err_code, step, mr_q, emr1_q, emr2_q, emr3_q
  );

  // Checker side: samples the command pins, reports status.
  modport slave (
    input  ddr2_cke, ddr2_cs_n, ddr2_ras_n, ddr2_cas_n, ddr2_we_n,
           ddr2_ba, ddr2_addr,
    output init_done, err, err_code, step, mr_q, emr1_q, emr2_q, emr3_q
  );
endinterface
`default_nettype wire

// File: rtl/ddr2_init_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : ddr2_init_checker
// Brief   : Watches the DDR2 command bus during power-up, checks the command
//           order, field values and command spacing, captures MR/EMRx writes
//           and latches the first violation.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
module ddr2_init_checker #(
  parameter int BA_BITS   = 3,
  parameter int ADDR_BITS = 13,
  parameter int TRP_CK    = 4,
  parameter int TRFC_CK   = 26,
  parameter int TMRD_CK   = 2
) (
  input  wire logic ck,
  input  wire logic rst,
  ddr2_init_checker_if.slave bus
);

  // Expected-step encoding (value is also the visible step index)
  localparam logic [3:0] ST_WAIT_CKE = 4'd0;
  localparam logic [3:0] ST_PRE_1    = 4'd1;
  localparam logic [3:0] ST_EMR2     = 4'd2;
  localparam logic [3:0] ST_EMR3     = 4'd3;
  localparam logic [3:0] ST_EMR1_DLL = 4'd4;
  localparam logic [3:0] ST_MR_RST   = 4'd5;
  localparam logic [3:0] ST_PRE_2    = 4'd6;
  localparam logic [3:0] ST_REF_1    = 4'd7;
  localparam logic [3:0] ST_REF_2    = 4'd8;
  localparam logic [3:0] ST_MR_RUN   = 4'd9;
  localparam logic [3:0] ST_EMR1_OCD = 4'd10;
  localparam logic [3:0] ST_EMR1_EXT = 4'd11;
  localparam logic [3:0] ST_DONE     = 4'd12;

  // Decoded command kinds
  localparam logic [2:0] K_IDLE = 3'd0;
  localparam logic [2:0] K_PRE  = 3'd1;
  localparam logic [2:0] K_REF  = 3'd2;
  localparam logic [2:0] K_MRS  = 3'd3;
  localparam logic [2:0] K_ILL  = 3'd4;

  // Class of the last accepted command, selects the spacing limit
  localparam logic [1:0] CLS_NONE = 2'd0;
  localparam logic [1:0] CLS_PRE  = 2'd1;
  localparam logic [1:0] CLS_REF  = 2'd2;
  localparam logic [1:0] CLS_MRS  = 2'd3;

  // Violation codes
  localparam logic [3:0] E_CMD   = 4'd1;
  localparam logic [3:0] E_FIELD = 4'd2;
  localparam logic [3:0] E_TRP   = 4'd3;
  localparam logic [3:0] E_TRFC  = 4'd4;
  localparam logic [3:0] E_TMRD  = 4'd5;
  localparam logic [3:0] E_CKE   = 4'd6;
  localparam logic [3:0] E_ILL   = 4'd7;

  localparam logic [5:0] GAP_MAX = 6'd63;

  // Limits widened by one bit so a limit above the saturation value can
  // never be met rather than silently wrapping.
  localparam logic [6:0] LIM_TRP  = (TRP_CK  > 127) ? 7'd127 : 7'(TRP_CK);
  localparam logic [6:0] LIM_TRFC = (TRFC_CK > 127) ? 7'd127 : 7'(TRFC_CK);
  localparam logic [6:0] LIM_TMRD = (TMRD_CK > 127) ? 7'd127 : 7'(TMRD_CK);

  // Registered pin samples
  logic                 cke_q;
  logic [3:0]           cmd_q;
  logic [BA_BITS-1:0]   ba_q;
  logic [ADDR_BITS-1:0] addr_q;

  // Checker state
  logic [3:0]           step_q,      step_d;
  logic                 init_done_q, init_done_d;
  logic                 err_q,       err_d;
  logic [3:0]           err_code_q,  err_code_d;
  logic [ADDR_BITS-1:0] mr_reg_q,    mr_reg_d;
  logic [ADDR_BITS-1:0] emr1_reg_q,  emr1_reg_d;
  logic [ADDR_BITS-1:0] emr2_reg_q,  emr2_reg_d;
  logic [ADDR_BITS-1:0] emr3_reg_q,  emr3_reg_d;
  logic [5:0]           gap_q,       gap_d;
  logic [1:0]           cls_q,       cls_d;

  // Combinational decode / check results
  logic [2:0] kind;
  logic [2:0] exp_kind;
  logic [1:0] exp_ba;
  logic       cmd_ok;
  logic       field_ok;
  logic       timing_bad;
  logic [3:0] timing_code;

  // Only ba[1:0] selects a mode register; upper bank bits are don't-care.
  if (BA_BITS > 2) begin : g_ba_hi
    logic unused_ba_hi;
    assign unused_ba_hi = ^ba_q[BA_BITS-1:2];
  end

  // Sample the command pins once per clock; reset to an idle deselect.
  always_ff @(posedge ck) begin
    if (rst) begin
      cke_q  <= 1'b0;
      cmd_q  <= 4'b1111;
      ba_q   <= '0;
      addr_q <= '0;
    end else begin
      cke_q  <= bus.ddr2_cke;
      cmd_q  <= {bus.ddr2_cs_n, bus.ddr2_ras_n, bus.ddr2_cas_n, bus.ddr2_we_n};
      ba_q   <= bus.ddr2_ba;
      addr_q <= bus.ddr2_addr;
    end
  end

  // Decode the sampled command into a kind.
  always_comb begin
    kind = K_ILL;
    if (cmd_q[3] || (cmd_q == 4'b0111)) begin
      kind = K_IDLE;
    end else begin
      case (cmd_q)
        4'b0010: kind = K_PRE;
        4'b0001: kind = K_REF;
        4'b0000: kind = K_MRS;
        default: kind = K_ILL;
      endcase
    end
  end

  // Expected command, MRS target and field rule for the current step.
  always_comb begin
    exp_kind = K_IDLE;
    exp_ba   = 2'd0;
    field_ok = 1'b1;
    case (step_q)
      ST_PRE_1, ST_PRE_2: begin
        exp_kind = K_PRE;
        field_ok = addr_q[10];
      end
      ST_EMR2: begin
        exp_kind = K_MRS;
        exp_ba   = 2'd2;
      end
      ST_EMR3: begin
        exp_kind = K_MRS;
        exp_ba   = 2'd3;
      end
      ST_EMR1_DLL: begin
        exp_kind = K_MRS;
        exp_ba   = 2'd1;
        field_ok = ~addr_q[0];
      end
      ST_MR_RST: begin
        exp_kind = K_MRS;
        exp_ba   = 2'd0;
        field_ok = addr_q[8];
      end
      ST_REF_1, ST_REF_2: begin
        exp_kind = K_REF;
      end
      ST_MR_RUN: begin
        exp_kind = K_MRS;
        exp_ba   = 2'd0;
        field_ok = ~addr_q[8];
      end
      ST_EMR1_OCD: begin
        exp_kind = K_MRS;
        exp_ba   = 2'd1;
        field_ok = (addr_q[9:7] == 3'b111);
      end
      ST_EMR1_EXT: begin
        exp_kind = K_MRS;
        exp_ba   = 2'd1;
        field_ok = (addr_q[9:7] == 3'b000);
      end
      default: begin
        exp_kind = K_IDLE;
        exp_ba   = 2'd0;
        field_ok = 1'b1;
      end
    endcase
    cmd_ok = (kind == exp_kind) && ((kind != K_MRS) || (ba_q[1:0] == exp_ba));
  end

  // Spacing check against the limit of the previously accepted command.
  always_comb begin
    timing_bad  = 1'b0;
    timing_code = 4'd0;
    case (cls_q)
      CLS_PRE: begin
        timing_bad  = ({1'b0, gap_q} < LIM_TRP);
        timing_code = E_TRP;
      end
      CLS_REF: begin
        timing_bad  = ({1'b0, gap_q} < LIM_TRFC);
        timing_code = E_TRFC;
      end
      CLS_MRS: begin
        timing_bad  = ({1'b0, gap_q} < LIM_TMRD);
        timing_code = E_TMRD;
      end
      default: begin
        timing_bad  = 1'b0;
        timing_code = 4'd0;
      end
    endcase
  end

  // Step advance, violation capture and mode-register capture.
  always_comb begin
    step_d      = step_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    mr_reg_d    = mr_reg_q;
    emr1_reg_d  = emr1_reg_q;
    emr2_reg_d  = emr2_reg_q;
    emr3_reg_d  = emr3_reg_q;
    cls_d       = cls_q;
    gap_d       = (gap_q == GAP_MAX) ? GAP_MAX : 6'(gap_q + 6'd1);

    // After an error or once DONE, nothing but reset changes the outputs.
    if (!err_q && (step_q != ST_DONE)) begin
      if (step_q == ST_WAIT_CKE) begin
        if (cke_q) begin
          step_d = ST_PRE_1;
        end
      end else if (!cke_q) begin
        err_d      = 1'b1;
        err_code_d = E_CKE;
      end else if (kind != K_IDLE) begin
        if (timing_bad) begin
          err_d      = 1'b1;
          err_code_d = timing_code;
        end else if (kind == K_ILL) begin
          err_d      = 1'b1;
          err_code_d = E_ILL;
        end else if (!cmd_ok) begin
          err_d      = 1'b1;
          err_code_d = E_CMD;
        end else if (!field_ok) begin
          err_d      = 1'b1;
          err_code_d = E_FIELD;
        end else begin
          step_d = 4'(step_q + 4'd1);
          gap_d  = 6'd1;
          if (step_q == ST_EMR1_EXT) begin
            init_done_d = 1'b1;
          end
          case (kind)
            K_PRE:   cls_d = CLS_PRE;
            K_REF:   cls_d = CLS_REF;
            default: cls_d = CLS_MRS;
          endcase
          if (kind == K_MRS) begin
            case (ba_q[1:0])
              2'd0:    mr_reg_d   = addr_q;
              2'd1:    emr1_reg_d = addr_q;
              2'd2:    emr2_reg_d = addr_q;
              default: emr3_reg_d = addr_q;
            endcase
          end
        end
      end
    end
  end

  // Checker state registers.
  always_ff @(posedge ck) begin
    if (rst) begin
      step_q      <= ST_WAIT_CKE;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 4'd0;
      mr_reg_q    <= '0;
      emr1_reg_q  <= '0;
      emr2_reg_q  <= '0;
      emr3_reg_q  <= '0;
      gap_q       <= GAP_MAX;
      cls_q       <= CLS_NONE;
    end else begin
      step_q      <= step_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      mr_reg_q    <= mr_reg_d;
      emr1_reg_q  <= emr1_reg_d;
      emr2_reg_q  <= emr2_reg_d;
      emr3_reg_q  <= emr3_reg_d;
      gap_q       <= gap_d;
      cls_q       <= cls_d;
    end
  end

  assign bus.init_done = init_done_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;
  assign bus.step      = step_q;
  assign bus.mr_q      = mr_reg_q;
  assign bus.emr1_q    = emr1_reg_q;
  assign bus.emr2_q    = emr2_reg_q;
  assign bus.emr3_q    = emr3_reg_q;

endmodule
`default_nettype wire
